i_decode: RTL and testbench

I_DECODE -- requirements
Module: idecode

---
 rtl/i_decode.sv | 124 ++++++++++++
 tb/tb_i_decode.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/i_decode.sv
// Instruction decode stage: register file with write-through bypass, opcode
// control decode, sign extension, and the ID/EX pipeline latch.
module i_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_instrout,
  input  logic [31:0] IF_ID_npcout,
  input  logic [4:0]  MEM_WB_rd,
  input  logic        MEM_WB_regwrite,
  input  logic [31:0] WB_mux5_writedata,
  output logic [1:0]  wb_ctlout,
  output logic [2:0]  m_ctlout,
  output logic        regdst,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic [31:0] npcout,
  output logic [31:0] rdata1out,
  output logic [31:0] rdata2out,
  output logic [31:0] s_extendout,
  output logic [4:0]  instrout_2016,
  output logic [4:0]  instrout_1511
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100
  } opcode_e;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic [2:0] m_ctl;
    logic [1:0] wb_ctl;
  } ctl_t;

  logic [31:0] regs [32];
  logic [5:0]  opcode;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        wr_en;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] s_extend;
  ctl_t        ctl;

  assign opcode   = IF_ID_instrout[31:26];
  assign rs_addr  = IF_ID_instrout[25:21];
  assign rt_addr  = IF_ID_instrout[20:16];
  assign s_extend = {{16{IF_ID_instrout[15]}}, IF_ID_instrout[15:0]};
  assign wr_en    = MEM_WB_regwrite && (MEM_WB_rd != 5'd0);

  // Register 0 is never written because wr_en excludes rd == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[MEM_WB_rd] <= WB_mux5_writedata;
    end
  end

  // The write-back value bypasses the array so a same-edge write is seen by the latch.
  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == 5'd0) begin
      rs_data = '0;
    end else if (wr_en && (MEM_WB_rd == rs_addr)) begin
      rs_data = WB_mux5_writedata;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == 5'd0) begin
      rt_data = '0;
    end else if (wr_en && (MEM_WB_rd == rt_addr)) begin
      rt_data = WB_mux5_writedata;
    end
  end

  always_comb begin
    ctl = '0;
    case (opcode)
      OP_RTYPE: ctl = '{regdst: 1'b1, alusrc: 1'b0, aluop: 2'b10, m_ctl: 3'b000, wb_ctl: 2'b10};
      OP_LW:    ctl = '{regdst: 1'b0, alusrc: 1'b1, aluop: 2'b00, m_ctl: 3'b010, wb_ctl: 2'b11};
      OP_SW:    ctl = '{regdst: 1'b0, alusrc: 1'b1, aluop: 2'b00, m_ctl: 3'b001, wb_ctl: 2'b00};
      OP_BEQ:   ctl = '{regdst: 1'b0, alusrc: 1'b0, aluop: 2'b01, m_ctl: 3'b100, wb_ctl: 2'b00};
      default:  ctl = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ctlout     <= '0;
      m_ctlout      <= '0;
      regdst        <= 1'b0;
      alusrc        <= 1'b0;
      aluop         <= '0;
      npcout        <= '0;
      rdata1out     <= '0;
      rdata2out     <= '0;
      s_extendout   <= '0;
      instrout_2016 <= '0;
      instrout_1511 <= '0;
    end else begin
      wb_ctlout     <= ctl.wb_ctl;
      m_ctlout      <= ctl.m_ctl;
      regdst        <= ctl.regdst;
      alusrc        <= ctl.alusrc;
      aluop         <= ctl.aluop;
      npcout        <= IF_ID_npcout;
      rdata1out     <= rs_data;
      rdata2out     <= rt_data;
      s_extendout   <= s_extend;
      instrout_2016 <= IF_ID_instrout[20:16];
      instrout_1511 <= IF_ID_instrout[15:11];
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: expectations are pushed when stimulus is
// driven and popped after the capturing edge.
module tb_i_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_ID_instrout;
  logic [31:0] IF_ID_npcout;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_regwrite;
  logic [31:0] WB_mux5_writedata;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npcout;
  logic [31:0] rdata1out;
  logic [31:0] rdata2out;
  logic [31:0] s_extendout;
  logic [4:0]  instrout_2016;
  logic [4:0]  instrout_1511;

  always #5 clk = ~clk;

  i_decode dut (
    .clk               (clk),
    .rst               (rst),
    .IF_ID_instrout    (IF_ID_instrout),
    .IF_ID_npcout      (IF_ID_npcout),
    .MEM_WB_rd         (MEM_WB_rd),
    .MEM_WB_regwrite   (MEM_WB_regwrite),
    .WB_mux5_writedata (WB_mux5_writedata),
    .wb_ctlout         (wb_ctlout),
    .m_ctlout          (m_ctlout),
    .regdst            (regdst),
    .alusrc            (alusrc),
    .aluop             (aluop),
    .npcout            (npcout),
    .rdata1out         (rdata1out),
    .rdata2out         (rdata2out),
    .s_extendout       (s_extendout),
    .instrout_2016     (instrout_2016),
    .instrout_1511     (instrout_1511)
  );

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] npc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] sx;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_regs [32];
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Control table order: {regdst, alusrc, aluop, m_ctl, wb_ctl}
  function automatic logic [8:0] ctl_ref(input logic [5:0] op);
    case (op)
      6'b000000: return 9'b1_0_10_000_10;
      6'b100011: return 9'b0_1_00_010_11;
      6'b101011: return 9'b0_1_00_001_00;
      6'b000100: return 9'b0_0_01_100_00;
      default:   return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] read_ref(input logic [4:0] a, input logic wen,
                                           input logic [4:0] rd, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wen && rd != 5'd0 && rd == a) return wd;
    return model_regs[a];
  endfunction

  task automatic checkAll(input string tag, input exp_t e);
    checkOutput({tag, ".ctl"}, {23'd0, regdst, alusrc, aluop, m_ctlout, wb_ctlout}, {23'd0, e.ctl});
    checkOutput({tag, ".npc"}, npcout, e.npc);
    checkOutput({tag, ".rdata1"}, rdata1out, e.r1);
    checkOutput({tag, ".rdata2"}, rdata2out, e.r2);
    checkOutput({tag, ".sext"}, s_extendout, e.sx);
    checkOutput({tag, ".i2016"}, {27'd0, instrout_2016}, {27'd0, e.rt});
    checkOutput({tag, ".i1511"}, {27'd0, instrout_1511}, {27'd0, e.rd});
  endtask

  task automatic checkZero(input string tag);
    exp_t z;
    z = '{ctl: '0, npc: '0, r1: '0, r2: '0, sx: '0, rt: '0, rd: '0};
    checkAll(tag, z);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic [31:0] npc,
                               input logic wen, input logic [4:0] rd, input logic [31:0] wd);
    exp_t e;
    exp_t got;
    @(negedge clk);
    IF_ID_instrout    = instr;
    IF_ID_npcout      = npc;
    MEM_WB_regwrite   = wen;
    MEM_WB_rd         = rd;
    WB_mux5_writedata = wd;
    e.ctl = ctl_ref(instr[31:26]);
    e.npc = npc;
    e.r1  = read_ref(instr[25:21], wen, rd, wd);
    e.r2  = read_ref(instr[20:16], wen, rd, wd);
    e.sx  = {{16{instr[15]}}, instr[15:0]};
    e.rt  = instr[20:16];
    e.rd  = instr[15:11];
    sb.push_back(e);
    @(posedge clk);
    if (wen && rd != 5'd0) model_regs[rd] = wd;
    #1;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: scoreboard empty, got nothing, expected one entry", tag);
    end else begin
      got = sb.pop_front();
      checkAll(tag, got);
    end
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] instr;
    clearModel();
    rst               = 1'b1;
    IF_ID_instrout    = 32'h8C22_FFFC;
    IF_ID_npcout      = 32'h0000_0044;
    MEM_WB_regwrite   = 1'b1;
    MEM_WB_rd         = 5'd5;
    WB_mux5_writedata = 32'hDEAD_BEEF;
    #22;
    checkZero("reset");
    @(negedge clk);
    rst             = 1'b0;
    MEM_WB_regwrite = 1'b0;

    // r5 must still be zero: the write attempted during reset is blocked
    applyStimulus("blocked_wr", 32'h00A6_3820, 32'h0000_0100, 1'b0, 5'd0, 32'd0);
    applyStimulus("wr_r5",      32'h0000_0000, 32'h0000_0104, 1'b1, 5'd5, 32'h0000_00AA);
    applyStimulus("add",        32'h00A6_3820, 32'h0000_0108, 1'b0, 5'd0, 32'd0);
    applyStimulus("lw",         32'h8C22_FFFC, 32'h0000_0004, 1'b0, 5'd0, 32'd0);
    applyStimulus("bypass_r1",  32'h8C22_FFFC, 32'h0000_0008, 1'b1, 5'd1, 32'h0000_1234);
    applyStimulus("bypass_rt",  32'h0025_0000, 32'h0000_000C, 1'b1, 5'd5, 32'h5555_0001);
    applyStimulus("wr_r0",      32'h0000_3820, 32'h0000_0010, 1'b1, 5'd0, 32'hFFFF_FFFF);
    applyStimulus("rd_r0",      32'h0000_3820, 32'h0000_0014, 1'b0, 5'd0, 32'd0);
    applyStimulus("beq",        32'h1022_0003, 32'h0000_0018, 1'b0, 5'd0, 32'd0);
    applyStimulus("bubble",     32'hFC00_0000, 32'h0000_001C, 1'b0, 5'd0, 32'd0);
    applyStimulus("sw",         32'hAC45_8001, 32'h0000_0020, 1'b1, 5'd2, 32'hCAFE_0002);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       op = 6'b000000;
        1:       op = 6'b100011;
        2:       op = 6'b101011;
        3:       op = 6'b000100;
        default: op = 6'($urandom_range(0, 63));
      endcase
      instr = {op, 26'($urandom)};
      applyStimulus("rand", instr, $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), $urandom);
    end

    applyStimulus("pre_midrst", 32'h8C22_FFFC, 32'h0000_0004, 1'b0, 5'd0, 32'd0);
    #2;
    rst               = 1'b1;
    MEM_WB_regwrite   = 1'b1;
    MEM_WB_rd         = 5'd7;
    WB_mux5_writedata = 32'h0000_0055;
    #1;
    checkZero("midrst");
    clearModel();
    @(posedge clk);
    #1;
    checkZero("rst_hold");
    @(negedge clk);
    rst             = 1'b0;
    MEM_WB_regwrite = 1'b0;
    applyStimulus("post_rst_r5", 32'h00A6_3820, 32'h0000_0200, 1'b0, 5'd0, 32'd0);
    applyStimulus("post_rst_r7", 32'h00E1_0000, 32'h0000_0204, 1'b0, 5'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
